// File: rtl/idecode_stage_if.sv
// rtl/idecode_stage_if.sv - instruction in / decoded-entry out handshake bundle
interface idecode_stage_if #(
    parameter int INSTR_W = 16,
    parameter int OPC_W   = 4,
    parameter int FLD_W   = 6
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [OPC_W-1:0]   out_opcode;
    logic [FLD_W-1:0]   out_a;
    logic [FLD_W-1:0]   out_b;
    logic [3:0]         out_class;
    logic               out_illegal;
    logic               out_raw;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_opcode, out_a, out_b, out_class, out_illegal, out_raw
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_opcode, out_a, out_b, out_class, out_illegal, out_raw
    );
endinterface

// File: rtl/idecode_stage.sv
// rtl/idecode_stage.sv - registered instruction decoder with RAW flagging and a small result FIFO
module idecode_stage #(
    parameter int INSTR_W = 16,
    parameter int OPC_W   = 4,
    parameter int FLD_W   = 6,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    idecode_stage_if.slave   bus,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] illegal_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [FLD_W-1:0] a;
        logic [FLD_W-1:0] b;
        logic [3:0]       cls;
        logic             illegal;
        logic             raw;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] count;
    logic [FLD_W-1:0] last_dst;
    logic             last_wr_valid;

    logic [OPC_W-1:0] opc;
    logic [FLD_W-1:0] fa;
    logic [FLD_W-1:0] fb;
    logic             writes;
    logic             reads_a;
    logic             reads_b;
    entry_t           dec;
    entry_t           head;
    logic             push;
    logic             pop;

    assign opc = bus.in_instr[INSTR_W-1 -: OPC_W];
    assign fa  = bus.in_instr[2*FLD_W-1:FLD_W];
    assign fb  = bus.in_instr[FLD_W-1:0];

    // Class bits are {MOV, IMM, MEM, ALU}; E/F decode as illegal with no register use
    always_comb begin
        dec         = '0;
        writes      = 1'b0;
        reads_a     = 1'b0;
        reads_b     = 1'b0;
        dec.opcode  = opc;
        dec.a       = fa;
        dec.b       = fb;
        case (int'(opc))
            1, 2, 3, 4, 5, 6, 7: begin dec.cls = 4'b0001; writes = 1'b1; reads_a = 1'b1; reads_b = 1'b1; end
            8, 9:                begin dec.cls = 4'b0100; writes = 1'b1; reads_a = 1'b1; end
            10:                  begin dec.cls = 4'b1000; writes = 1'b1; reads_b = 1'b1; end
            11:                  begin dec.cls = 4'b1000; writes = 1'b1; end
            12:                  begin dec.cls = 4'b0010; writes = 1'b1; reads_b = 1'b1; end
            13:                  begin dec.cls = 4'b0010; reads_a = 1'b1; reads_b = 1'b1; end
            14, 15:              dec.illegal = 1'b1;
            default:             ;
        endcase
        dec.raw = last_wr_valid && ((reads_a && fa == last_dst) || (reads_b && fb == last_dst));
    end

    assign bus.in_ready  = (count != OCC_W'(DEPTH));
    assign bus.out_valid = (count != '0);
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // Outputs are forced to zero while empty so stale slots never show
    assign head            = mem[rd_ptr];
    assign bus.out_opcode  = bus.out_valid ? head.opcode  : '0;
    assign bus.out_a       = bus.out_valid ? head.a       : '0;
    assign bus.out_b       = bus.out_valid ? head.b       : '0;
    assign bus.out_class   = bus.out_valid ? head.cls     : '0;
    assign bus.out_illegal = bus.out_valid ? head.illegal : 1'b0;
    assign bus.out_raw     = bus.out_valid ? head.raw     : 1'b0;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            last_dst      <= '0;
            last_wr_valid <= 1'b0;
            instr_count   <= '0;
            illegal_count <= '0;
        end else if (flush) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            last_wr_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr        <= wr_ptr + 1'b1;
                last_dst      <= fa;
                last_wr_valid <= writes;
                if (instr_count != '1) begin
                    instr_count <= instr_count + 1'b1;
                end
                if (dec.illegal && illegal_count != '1) begin
                    illegal_count <= illegal_count + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_idecode_stage.sv
// tb/tb_idecode_stage.sv - scoreboard bench for idecode_stage with a rule-level reference model
module tb_idecode_stage;
    localparam int DEPTH = 2;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] illegal_count;

    idecode_stage_if #(.INSTR_W(16), .OPC_W(4), .FLD_W(6)) bus ();

    idecode_stage #(.INSTR_W(16), .OPC_W(4), .FLD_W(6), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .bus           (bus),
        .instr_count   (instr_count),
        .illegal_count (illegal_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] opc;
        logic [5:0] a;
        logic [5:0] b;
        logic [3:0] cls;
        logic       ill;
        logic       raw;
        logic       wr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic       m_wr = 1'b0;
    logic [5:0] m_dst = '0;
    int   m_ic = 0;
    int   m_il = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] ins, input logic pw, input logic [5:0] pd);
        exp_t e;
        int   op;
        logic alu, imm, mov, mem, ra, rb;
        op    = int'(ins[15:12]);
        e.opc = ins[15:12];
        e.a   = ins[11:6];
        e.b   = ins[5:0];
        alu   = (op >= 1 && op <= 7);
        imm   = (op == 8 || op == 9);
        mov   = (op == 10 || op == 11);
        mem   = (op == 12 || op == 13);
        e.cls = {mov, imm, mem, alu};
        e.ill = (op >= 14);
        e.wr  = alu || imm || mov || op == 12;
        ra    = alu || imm || op == 13;
        rb    = alu || op == 10 || op == 12 || op == 13;
        e.raw = pw && ((ra && e.a == pd) || (rb && e.b == pd));
        return e;
    endfunction

    // Stimulus side of the scoreboard: record every accepted instruction
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_wr = 1'b0;
            m_ic = 0;
            m_il = 0;
        end else begin
            chk("instr_count", 32'(instr_count), 32'(m_ic));
            chk("illegal_count", 32'(illegal_count), 32'(m_il));
            if (flush) begin
                q.delete();
                m_wr = 1'b0;
            end else if (bus.in_valid && bus.in_ready) begin
                exp_t e;
                e = model(bus.in_instr, m_wr, m_dst);
                q.push_back(e);
                m_wr  = e.wr;
                m_dst = e.a;
                if (m_ic < CMAX) m_ic++;
                if (e.ill && m_il < CMAX) m_il++;
            end
        end
    end

    // Monitor: compare head against scoreboard, pop on an accepted transfer
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
            chk("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL head_unexpected actual=valid expected=empty t=%0t", $time);
                end else begin
                    chk("out_opcode", 32'(bus.out_opcode), 32'(q[0].opc));
                    chk("out_a", 32'(bus.out_a), 32'(q[0].a));
                    chk("out_b", 32'(bus.out_b), 32'(q[0].b));
                    chk("out_class", 32'(bus.out_class), 32'(q[0].cls));
                    chk("out_illegal", 32'(bus.out_illegal), 32'(q[0].ill));
                    chk("out_raw", 32'(bus.out_raw), 32'(q[0].raw));
                    if (bus.out_ready && !flush) void'(q.pop_front());
                end
            end
        end
    end

    task automatic push(input logic [15:0] ins);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL push_timeout actual=not_accepted expected=accepted instr=0x%0h", ins);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_fields"}, {bus.out_opcode, bus.out_a, bus.out_b, bus.out_class, bus.out_illegal, bus.out_raw}, 32'd0);
        chk({tag, "_instr_count"}, 32'(instr_count), 32'd0);
        chk({tag, "_illegal_count"}, 32'(illegal_count), 32'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b0;
        idle(2);
        check_zero("reset");
        rst_n = 1'b1;
        idle(1);

        bus.out_ready = 1'b1;
        push(16'h10C5);
        idle(2);
        chk("first_count", 32'(instr_count), 32'd1);

        push(16'h10C5);
        push(16'h21C3);
        idle(2);
        push(16'h10C5);
        push(16'h0000);
        push(16'h21C3);
        idle(3);

        bus.out_ready = 1'b0;
        fork
            begin
                push(16'h10C5);
                push(16'h21C3);
                push(16'h3042);
            end
            begin
                idle(5);
                chk("full_in_ready", 32'(bus.in_ready), 32'd0);
                chk("held_head_opcode", 32'(bus.out_opcode), 32'd1);
                bus.out_ready = 1'b1;
            end
        join
        idle(4);

        push(16'hE000);
        push(16'hF03F);
        push(16'h2041);
        idle(3);

        bus.out_ready = 1'b0;
        push(16'h10C5);
        push(16'h21C3);
        bus.in_valid = 1'b1;
        bus.in_instr = 16'h30C5;
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        push(16'hB0C0);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_instr  = {4'($urandom_range(0, 15)), 6'($urandom_range(0, 3)), 6'($urandom_range(0, 3))};
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 24) == 0);
            idle(1);
        end
        bus.in_valid  = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        idle(3);

        for (int i = 0; i < 20; i++) push(16'h10C5 + 16'(i));
        idle(3);
        chk("sat_instr_count", 32'(instr_count), 32'(CMAX));

        bus.in_valid = 1'b1;
        bus.in_instr = 16'h8041;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        idle(2);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/idecode_stage.md
Name: idecode_stage

Overview:
- Parametrised, registered successor of the combinational instruction decoder.
- Accepts instructions over a valid/ready handshake, decodes opcode class and register fields, flags illegal opcodes and back-to-back register dependencies (RAW), and buffers decoded results in a small FIFO.
- Sits between instruction fetch and the ALU/memory/move datapaths.
- Keeps running counts of decoded and illegal instructions.

Parameters:
- INSTR_W, 16: instruction width; must equal OPC_W + 2*FLD_W.
- OPC_W, 4: opcode width, taken from the MSBs. Class map below assumes 4.
- FLD_W, 6: width of register fields A and B. A = bits [2*FLD_W-1:FLD_W], B = bits [FLD_W-1:0].
- DEPTH, 2: decoded-entry FIFO depth; power of two, ≥2.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- flush, in, 1: synchronous flush.
- in_valid, in, 1: instruction valid.
- in_ready, out, 1: stage can accept an instruction.
- in_instr, in, INSTR_W: instruction word.
- out_valid, out, 1: head entry valid.
- out_ready, in, 1: consumer accepts head.
- out_opcode, out, OPC_W: head opcode.
- out_a, out, FLD_W: head field A.
- out_b, out, FLD_W: head field B.
- out_class, out, 4: one-hot {MOVop, IMMop, MEMop, ALUop}, bit 0 = ALUop.
- out_illegal, out, 1: head opcode is illegal.
- out_raw, out, 1: head depends on the previous writer.
- instr_count, out, CNT_W: accepted instructions, saturating.
- illegal_count, out, CNT_W: accepted illegal instructions, saturating.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty; out_valid=0; in_ready=1.
  - All out_* fields = 0; counters = 0; last-writer tracking invalid.
- Handshakes:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = !full. No combinational in_valid→in_ready or out_ready→in_ready path; a full FIFO does not accept on the same cycle as a pop.
  - out_valid = !empty. out_* reflect the head entry only and are held stable while out_valid && !out_ready.
- Latency: an instruction pushed in cycle N appears at the head in N+1 when the FIFO was empty.
- Decode is done at push time and stored per entry:
  - Opcode 0: NOP. Class 0000, not illegal.
  - Opcodes 1–7: ALU. Writes A; reads A and B.
  - Opcodes 8–9: IMM. Writes A; reads A.
  - Opcode A (MOV): class MOV. Writes A; reads B.
  - Opcode B (MOVI): class MOV. Writes A; reads none.
  - Opcode C (LOAD): class MEM. Writes A; reads B.
  - Opcode D (STORE): class MEM. Writes none; reads A and B.
  - Opcodes E–F: illegal. Class 0000, out_illegal=1; writes none, reads none.
- RAW tracking:
  - Registers last_dst and last_wr_valid, updated on every push: last_wr_valid = writes(instr), last_dst = A.
  - out_raw for an entry = last_wr_valid at its push && the entry reads a field equal to last_dst.
  - Only the immediately previous accepted instruction is considered; an intervening NOP or STORE clears the dependency.
- Counters:
  - instr_count +1 per push; illegal_count +1 per illegal push.
  - Both saturate at 2^CNT_W−1; no wrap.
  - Not cleared by flush.
- Flush (synchronous):
  - Empties the FIFO, next cycle out_valid=0, clears last_wr_valid.
  - Has priority over a push or pop in the same cycle; that push is discarded and not counted.
- Pointer wrap: read/write pointers wrap modulo DEPTH. Full/empty are distinguished by an occupancy count of width log2(DEPTH)+1.
- Reset mid-operation: everything returns to reset values immediately, independent of clk.

Test Plan:
- Reset, then push 0x10C5 (ADD A=3, B=5) with out_ready=1 → next cycle out_valid=1, opcode=1, a=3, b=5, class=0001, raw=0, illegal=0; instr_count=1.
- Push 0x10C5 then 0x21C3 (SUB A=7, B=3) back-to-back → second entry raw=1. Repeat with 0x0000 inserted between them → SUB raw=0.
- Hold out_ready=0 and push 3 instructions → after 2 pushes in_ready=0, third is held, head stays 0x10C5 fields. Raise out_ready → entries drain in order and in_ready returns to 1.
- Push 0xE000 and 0xF03F → out_illegal=1, class=0000, illegal_count=2. A following 0x2041 (reads field 1) gives raw=0.
- With FIFO holding 2 entries, assert flush together with in_valid → next cycle out_valid=0 and instr_count unchanged by the flushed push. Next push 0xB0C0 (MOVI A=3) → raw=0.
- With CNT_W=4, push 20 instructions → instr_count stops at 15. Assert rst_n=0 mid-stream → all outputs 0 and in_ready=1 without a clock edge.
